axi4_sim_mem: RTL
=================

AXI4_SIM_MEM -- requirements
Module: axi4_sim_mem

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- ADDR_BITS, 32, AXI address width.
- DATA_BITS, 64, data width; power of two, 32..512.
- ID_BITS, 4, AXI ID width.
- DEPTH_WORDS, 1024, number of DATA_BITS words of backing storage.
- READ_LATENCY, 2, cycles from AR handshake to first R beat valid; 0..15.
REQ-002 SHALL have one clock; reset is asynchronous and active-low. Ports (name, direction, width, meaning), one per line:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  async active-low reset.
- io_mem_ar_valid/_ready  in/out  1  read address handshake.
- io_mem_ar_bits_addr  in  ADDR_BITS  read start address.
- io_mem_ar_bits_id  in  ID_BITS  read ID.
- io_mem_ar_bits_size  in  3  log2 bytes per beat.
- io_mem_ar_bits_len  in  8  beats minus 1.
- io_mem_aw_valid/_ready, io_mem_aw_bits_addr/_id/_size/_len  in/out  as AR  write address channel.
- io_mem_w_valid/_ready  in/out  1  write data handshake.
- io_mem_w_bits_data  in  DATA_BITS  write data.
- io_mem_w_bits_strb  in  DATA_BITS/8  byte enables.
- io_mem_w_bits_last  in  1  last write beat.
- io_mem_r_valid/_ready  out/in  1  read data handshake.
- io_mem_r_bits_data  out  DATA_BITS  read data.
- io_mem_r_bits_id  out  ID_BITS  captured AR ID.
- io_mem_r_bits_resp  out  2  read response.
- io_mem_r_bits_last  out  1  last read beat.
- io_mem_b_valid/_ready  out/in  1  write response handshake.
- io_mem_b_bits_id  out  ID_BITS  captured AW ID.
- io_mem_b_bits_resp  out  2  write response.

Function
REQ-003 SHALL compute word index = addr >> log2(DATA_BITS/8), ignoring low address bits; a beat is in range iff index < DEPTH_WORDS.
REQ-004 SHALL support INCR bursts only; ignore burst type; index increments by 1 per beat; no wrap.
REQ-005 SHALL run the read FSM as R_IDLE -> R_WAIT -> R_BURST -> R_IDLE, with io_mem_ar_ready=1 only in R_IDLE.
REQ-006 SHALL, on AR handshake, capture addr, id, and len, and load the latency counter with READ_LATENCY; if READ_LATENCY=0, go straight to R_BURST and assert r_valid the next cycle.
REQ-007 SHALL decrement the latency counter each cycle in R_WAIT and enter R_BURST when it reaches 0; r_valid=1 exactly in R_BURST.
REQ-008 SHALL, in R_BURST, present data = mem[index] (read combinationally from the array), r_id = captured id, and r_last=1 iff beat count == len; on r_ready, advance beat and index; after the last handshake go to R_IDLE.
REQ-009 SHALL return resp=2'b10, data=0 for out-of-range beats, or for all beats when size != log2(DATA_BITS/8); otherwise resp=2'b00. The burst always has len+1 beats.
REQ-010 SHALL run the write FSM as W_IDLE -> W_DATA -> W_RESP -> W_IDLE; aw_ready=1 only in W_IDLE, w_ready=1 only in W_DATA, b_valid=1 only in W_RESP.
REQ-011 SHALL, on each W handshake, write the bytes whose strb bit is 1 to mem[index] at the clock edge; out-of-range beats write nothing.
REQ-012 SHALL end the write burst on the beat where count == len, regardless of w_last; a w_last mismatch (asserted early, or absent on the final beat) sets the sticky error flag.
REQ-013 SHALL set the sticky error flag on a size mismatch or any out-of-range beat; in W_RESP, b_id = captured id and b_resp = 2'b10 if the error flag is set, else 2'b00; on b_ready go to W_IDLE and clear the flag.
REQ-014 SHALL run the read and write FSMs concurrently. A same-cycle read beat and write to the same word returns the old data.
REQ-015 SHALL use an 8-bit beat counter, so len=255 gives 256 beats; no overflow occurs.

Reset
REQ-016 SHALL, while reset_n=0, force both FSMs idle, the counters and error flag to 0, and the outputs to: ar_ready=1, aw_ready=1, w_ready=0, r_valid=0, b_valid=0, r_last=0, and resp/id/data=0.
REQ-017 SHALL abandon any in-flight burst on reset mid-operation, with no R beats or B response after reset_n rises; memory contents are not reset.

Verification
REQ-018 SHALL pass these directed scenarios (defaults):
- AW addr=0x40, len=3, then 4 W beats with strb=0xFF and data 1..4 -> one B, id matches, resp=0. Then AR addr=0x40, len=3 -> first r_valid 2 cycles after AR handshake, data 1..4, r_last on beat 4.
- W strb=0x0F, data=0xAAAA_AAAA_BBBB_BBBB over the word 0x1111_1111_2222_2222 -> readback 0x1111_1111_BBBB_BBBB.
- AR addr=0x1FF8, len=1 (index 1023, 1024) -> beat0 resp=0, beat1 resp=2'b10 with data=0.
- AW len=2 with w_last on the 2nd beat -> 3 beats accepted, b_resp=2'b10.
- AR len=7 with r_ready toggling every other cycle, concurrent with an AW/W burst -> ordered, correct data; ar_ready stays low until after the last R handshake.
- reset_n pulsed low mid-read-burst -> r_valid=0 immediately, no further beats, ar_ready=1.

Source files
------------

// File: rtl/axi4_sim_mem.sv
// AXI4 simulation memory: word-addressed backing store behind independent
// read and write burst engines (INCR only, single outstanding burst each).
module axi4_sim_mem #(
    parameter int ADDR_BITS    = 32,
    parameter int DATA_BITS    = 64,
    parameter int ID_BITS      = 4,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   io_mem_ar_valid,
    output logic                   io_mem_ar_ready,
    input  logic [ADDR_BITS-1:0]   io_mem_ar_bits_addr,
    input  logic [ID_BITS-1:0]     io_mem_ar_bits_id,
    input  logic [2:0]             io_mem_ar_bits_size,
    input  logic [7:0]             io_mem_ar_bits_len,
    input  logic                   io_mem_aw_valid,
    output logic                   io_mem_aw_ready,
    input  logic [ADDR_BITS-1:0]   io_mem_aw_bits_addr,
    input  logic [ID_BITS-1:0]     io_mem_aw_bits_id,
    input  logic [2:0]             io_mem_aw_bits_size,
    input  logic [7:0]             io_mem_aw_bits_len,
    input  logic                   io_mem_w_valid,
    output logic                   io_mem_w_ready,
    input  logic [DATA_BITS-1:0]   io_mem_w_bits_data,
    input  logic [DATA_BITS/8-1:0] io_mem_w_bits_strb,
    input  logic                   io_mem_w_bits_last,
    output logic                   io_mem_r_valid,
    input  logic                   io_mem_r_ready,
    output logic [DATA_BITS-1:0]   io_mem_r_bits_data,
    output logic [ID_BITS-1:0]     io_mem_r_bits_id,
    output logic [1:0]             io_mem_r_bits_resp,
    output logic                   io_mem_r_bits_last,
    output logic                   io_mem_b_valid,
    input  logic                   io_mem_b_ready,
    output logic [ID_BITS-1:0]     io_mem_b_bits_id,
    output logic [1:0]             io_mem_b_bits_resp
);

    localparam int BYTES  = DATA_BITS / 8;
    localparam int OFFS   = $clog2(BYTES);
    localparam int IDX_W  = ADDR_BITS - OFFS;
    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0]     FULL_SIZE = 3'(OFFS);
    localparam logic [IDX_W:0] DEPTH_L   = (IDX_W + 1)'(DEPTH_WORDS);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < DEPTH_L;
    endfunction

    logic [DATA_BITS-1:0] mem [DEPTH_WORDS];

    r_state_t         r_state_q, r_state_d;
    logic [IDX_W-1:0] r_idx_q, r_idx_d;
    logic [ID_BITS-1:0] r_id_q, r_id_d;
    logic [7:0]       r_len_q, r_len_d;
    logic [7:0]       r_cnt_q, r_cnt_d;
    logic [3:0]       r_lat_q, r_lat_d;
    logic             r_size_err_q, r_size_err_d;

    w_state_t         w_state_q, w_state_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic [ID_BITS-1:0] w_id_q, w_id_d;
    logic [7:0]       w_len_q, w_len_d;
    logic [7:0]       w_cnt_q, w_cnt_d;
    logic             w_err_q, w_err_d;

    logic r_beat_ok;
    logic w_is_last;
    logic mem_we;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^{io_mem_ar_bits_addr[OFFS-1:0], io_mem_aw_bits_addr[OFFS-1:0]};

    always_comb begin
        r_state_d    = r_state_q;
        r_idx_d      = r_idx_q;
        r_id_d       = r_id_q;
        r_len_d      = r_len_q;
        r_cnt_d      = r_cnt_q;
        r_lat_d      = r_lat_q;
        r_size_err_d = r_size_err_q;
        case (r_state_q)
            R_IDLE: begin
                if (io_mem_ar_valid) begin
                    r_idx_d      = io_mem_ar_bits_addr[ADDR_BITS-1:OFFS];
                    r_id_d       = io_mem_ar_bits_id;
                    r_len_d      = io_mem_ar_bits_len;
                    r_cnt_d      = 8'd0;
                    r_lat_d      = 4'(READ_LATENCY);
                    r_size_err_d = (io_mem_ar_bits_size != FULL_SIZE);
                    r_state_d    = (READ_LATENCY == 0) ? R_BURST : R_WAIT;
                end
            end
            R_WAIT: begin
                r_lat_d = r_lat_q - 4'd1;
                if (r_lat_q <= 4'd1) begin
                    r_lat_d   = 4'd0;
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (io_mem_r_ready) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d = r_cnt_q + 8'd1;
                        r_idx_d = r_idx_q + 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read data is taken straight from the array, so a write landing on the
    // same edge as the read handshake is not visible to that beat.
    assign r_beat_ok          = !r_size_err_q && in_range(r_idx_q);
    assign io_mem_ar_ready    = (r_state_q == R_IDLE);
    assign io_mem_r_valid     = (r_state_q == R_BURST);
    assign io_mem_r_bits_data = (io_mem_r_valid && r_beat_ok) ? mem[r_idx_q[MEM_AW-1:0]] : '0;
    assign io_mem_r_bits_resp = !io_mem_r_valid ? 2'b00 : (r_beat_ok ? RESP_OKAY : RESP_SLVERR);
    assign io_mem_r_bits_id   = io_mem_r_valid ? r_id_q : '0;
    assign io_mem_r_bits_last = io_mem_r_valid && (r_cnt_q == r_len_q);

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_id_d    = w_id_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_is_last = (w_cnt_q == w_len_q);
        case (w_state_q)
            W_IDLE: begin
                if (io_mem_aw_valid) begin
                    w_idx_d   = io_mem_aw_bits_addr[ADDR_BITS-1:OFFS];
                    w_id_d    = io_mem_aw_bits_id;
                    w_len_d   = io_mem_aw_bits_len;
                    w_cnt_d   = 8'd0;
                    w_err_d   = (io_mem_aw_bits_size != FULL_SIZE);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (io_mem_w_valid) begin
                    // The beat count, not w_last, terminates the burst.
                    if (!in_range(w_idx_q) || (io_mem_w_bits_last != w_is_last)) begin
                        w_err_d = 1'b1;
                    end
                    if (w_is_last) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q + 8'd1;
                        w_idx_d = w_idx_q + 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (io_mem_b_ready) begin
                    w_err_d   = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign io_mem_aw_ready    = (w_state_q == W_IDLE);
    assign io_mem_w_ready     = (w_state_q == W_DATA);
    assign io_mem_b_valid     = (w_state_q == W_RESP);
    assign io_mem_b_bits_id   = io_mem_b_valid ? w_id_q : '0;
    assign io_mem_b_bits_resp = (io_mem_b_valid && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign mem_we             = (w_state_q == W_DATA) && io_mem_w_valid && in_range(w_idx_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q    <= R_IDLE;
            r_idx_q      <= '0;
            r_id_q       <= '0;
            r_len_q      <= '0;
            r_cnt_q      <= '0;
            r_lat_q      <= '0;
            r_size_err_q <= 1'b0;
            w_state_q    <= W_IDLE;
            w_idx_q      <= '0;
            w_id_q       <= '0;
            w_len_q      <= '0;
            w_cnt_q      <= '0;
            w_err_q      <= 1'b0;
        end else begin
            r_state_q    <= r_state_d;
            r_idx_q      <= r_idx_d;
            r_id_q       <= r_id_d;
            r_len_q      <= r_len_d;
            r_cnt_q      <= r_cnt_d;
            r_lat_q      <= r_lat_d;
            r_size_err_q <= r_size_err_d;
            w_state_q    <= w_state_d;
            w_idx_q      <= w_idx_d;
            w_id_q       <= w_id_d;
            w_len_q      <= w_len_d;
            w_cnt_q      <= w_cnt_d;
            w_err_q      <= w_err_d;
        end
    end

    // Storage is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (io_mem_w_bits_strb[i]) begin
                    mem[w_idx_q[MEM_AW-1:0]][8*i +: 8] <= io_mem_w_bits_data[8*i +: 8];
                end
            end
        end
    end

endmodule
